// File: rtl/fft2d_pkg.sv
// Shared definitions for the 2-D FFT corner-turn path.
// Holds the default transform geometry, the sample width and the
// FILL/DRAIN state encoding used by corner_turn_128x128.
package fft2d_pkg;
    localparam int N     = 128;           // transform side length (power of 2)
    localparam int W     = 16;            // width of one real/imag component
    localparam int LOG2N = $clog2(N);
    localparam int SW    = 2 * W;         // packed sample {imag, real}

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;
endpackage

// File: rtl/transpose_ram.sv
// Simple dual-port frame store for the corner turn.
// Ports:
//   clk      - write and read clock
//   i_we     - write enable, i_waddr/i_wdata - write port
//   i_re     - read enable,  i_raddr         - read address
//   o_rdata  - read data, valid one cycle after i_re, held otherwise
// No reset on purpose so the array maps onto block RAM.
module transpose_ram
    import fft2d_pkg::*;
#(
    parameter int DEPTH = N * N,
    parameter int AW    = 2 * LOG2N,
    parameter int DW    = SW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata        <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/corner_turn_128x128.sv
// Corner turn (matrix transpose) between the row and column FFT passes.
// FILL accepts N*N samples in row-major order into transpose_ram; DRAIN
// reads them back column-major. The output side keeps an output register
// plus one skid entry so a 1-cycle RAM read still gives full throughput
// and stable data while the consumer stalls.
// Ports:
//   clk, reset (async, active low)
//   s_axis_data_*  - row-ordered input stream, tdata = {imag, real}
//   m_axis_data_*  - column-ordered output stream, same packing
//   event_tlast_unexpected / event_tlast_missing - input framing pulses
//   frame_done     - pulse on the cycle after the last output handshake
module corner_turn_128x128 #(
    parameter int N = fft2d_pkg::N,
    parameter int W = fft2d_pkg::W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2*W-1:0] s_axis_data_tdata,
    input  logic           s_axis_data_tvalid,
    output logic           s_axis_data_tready,
    input  logic           s_axis_data_tlast,
    output logic [2*W-1:0] m_axis_data_tdata,
    output logic           m_axis_data_tvalid,
    input  logic           m_axis_data_tready,
    output logic           m_axis_data_tlast,
    output logic           event_tlast_unexpected,
    output logic           event_tlast_missing,
    output logic           frame_done
);
    import fft2d_pkg::*;

    localparam int LN    = $clog2(N);
    localparam int AW    = 2 * LN;
    localparam int DW    = 2 * W;
    localparam int DEPTH = N * N;

    logic [0:0]    r_state;
    logic [AW-1:0] r_wr_k, r_rd_k, r_out_k;
    logic          r_rd_done;
    logic          r_s_tready;
    logic          r_inflight, r_inflight_last;
    logic          r_ovld, r_olast, r_skvld, r_sklast;
    logic [DW-1:0] r_odata, r_skdata;
    logic          r_ev_unexp, r_ev_miss, r_frame_done;

    logic          w_in_hs, w_in_last, w_out_hs, w_out_last, w_col_last, w_rd_en;
    logic [1:0]    w_busy;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_rd_data;

    assign w_in_hs    = s_axis_data_tvalid & r_s_tready;
    assign w_in_last  = w_in_hs & (&r_wr_k);
    assign w_out_hs   = r_ovld & m_axis_data_tready;
    assign w_out_last = w_out_hs & (&r_out_k);
    assign w_col_last = &r_wr_k[LN-1:0];

    // Entries that will occupy the output register / skid after this edge.
    // A new read may issue only if its data is guaranteed a slot next edge.
    assign w_busy  = 2'(r_ovld) + 2'(r_skvld) + 2'(r_inflight);
    assign w_rd_en = (r_state == ST_DRAIN) & ~r_rd_done &
                     ((w_busy - 2'(w_out_hs)) <= 2'd1);

    // Column-major walk: swapping the row/column halves of k is
    // (k mod N)*N + (k div N).
    assign w_rd_addr = {r_rd_k[LN-1:0], r_rd_k[AW-1:LN]};

    transpose_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
        .clk     (clk),
        .i_we    (w_in_hs),
        .i_waddr (r_wr_k),
        .i_wdata (s_axis_data_tdata),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_FILL;
            r_wr_k          <= '0;
            r_rd_k          <= '0;
            r_out_k         <= '0;
            r_rd_done       <= 1'b0;
            r_s_tready      <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_ovld          <= 1'b0;
            r_olast         <= 1'b0;
            r_odata         <= '0;
            r_skvld         <= 1'b0;
            r_sklast        <= 1'b0;
            r_skdata        <= '0;
            r_ev_unexp      <= 1'b0;
            r_ev_miss       <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= w_out_last;
            r_ev_unexp   <= w_in_hs &  s_axis_data_tlast & ~w_col_last;
            r_ev_miss    <= w_in_hs & ~s_axis_data_tlast &  w_col_last;

            // tready is the registered "next state is FILL", so it also
            // rises on the first edge after reset release.
            if (r_state == ST_FILL) begin
                r_s_tready <= ~w_in_last;
                if (w_in_last) r_state <= ST_DRAIN;
            end else begin
                r_s_tready <= w_out_last;
                if (w_out_last) r_state <= ST_FILL;
            end

            if (w_in_hs)  r_wr_k  <= r_wr_k + 1'b1;
            if (w_out_hs) r_out_k <= r_out_k + 1'b1;
            if (w_rd_en) begin
                r_rd_k <= r_rd_k + 1'b1;
                if (&r_rd_k) r_rd_done <= 1'b1;
            end
            if (w_out_last) r_rd_done <= 1'b0;

            r_inflight <= w_rd_en;
            if (w_rd_en) r_inflight_last <= &r_rd_k[LN-1:0];

            // Output register refills from skid first, then from the RAM;
            // RAM data that arrives while the output is stalled parks in skid.
            if (!r_ovld || w_out_hs) begin
                if (r_skvld) begin
                    r_ovld  <= 1'b1;
                    r_odata <= r_skdata;
                    r_olast <= r_sklast;
                    r_skvld <= r_inflight;
                    if (r_inflight) begin
                        r_skdata <= w_rd_data;
                        r_sklast <= r_inflight_last;
                    end
                end else if (r_inflight) begin
                    r_ovld  <= 1'b1;
                    r_odata <= w_rd_data;
                    r_olast <= r_inflight_last;
                end else begin
                    r_ovld <= 1'b0;
                end
            end else if (r_inflight) begin
                r_skvld  <= 1'b1;
                r_skdata <= w_rd_data;
                r_sklast <= r_inflight_last;
            end
        end
    end

    assign s_axis_data_tready     = r_s_tready;
    assign m_axis_data_tdata      = r_odata;
    assign m_axis_data_tvalid     = r_ovld;
    assign m_axis_data_tlast      = r_olast;
    assign event_tlast_unexpected = r_ev_unexp;
    assign event_tlast_missing    = r_ev_miss;
    assign frame_done             = r_frame_done;
endmodule

// File: doc/corner_turn_128x128.md
CORNER_TURN_128X128 -- requirements
Module: corner_turn_128x128

Interface
REQ-001 Parameter N, default 128, transform side length (power of 2).
REQ-002 Parameter W, default 16, width of each real/imag component.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 s_axis_data_tdata  input  2W  row-FFT sample; [2W-1:W] imag, [W-1:0] real.
REQ-006 s_axis_data_tvalid  input  1  upstream sample valid.
REQ-007 s_axis_data_tready  output  1  block accepts a sample.
REQ-008 s_axis_data_tlast  input  1  upstream marks last sample of a row.
REQ-009 m_axis_data_tdata  output  2W  column-ordered sample to column FFT, same packing.
REQ-010 m_axis_data_tvalid  output  1  output sample valid.
REQ-011 m_axis_data_tready  input  1  downstream accepts.
REQ-012 m_axis_data_tlast  output  1  last sample of a column.
REQ-013 event_tlast_unexpected  output  1  one-cycle pulse, tlast high on non-final row sample.
REQ-014 event_tlast_missing  output  1  one-cycle pulse, tlast low on final row sample.
REQ-015 frame_done  output  1  one-cycle pulse after last output handshake of a frame.

Function
REQ-016 Two states: FILL (accept N*N inputs), DRAIN (emit N*N outputs); FILL->DRAIN after input handshake N*N-1, DRAIN->FILL after output handshake N*N-1.
REQ-017 Handshake occurs when valid and ready both high on a posedge; no other event advances any counter.
REQ-018 s_axis_data_tready high exactly while in FILL; low throughout DRAIN.
REQ-019 Input handshake k (0..N*N-1) writes sample to address k (row-major).
REQ-020 Output handshake k delivers mem[(k mod N)*N + (k div N)] (column-major).
REQ-021 m_axis_data_tlast high when (k mod N) = N-1.
REQ-022 tlast checking per input handshake: column index = k mod N; pulse event_tlast_unexpected if tlast and index != N-1; pulse event_tlast_missing if !tlast and index = N-1; sample still written at address k; no resynchronisation.
REQ-023 m_axis_data_tvalid first asserts no later than 2 cycles after entering DRAIN.
REQ-024 With m_axis_data_tready held high, output sustains one sample per cycle, no bubbles.
REQ-025 While m_axis_data_tvalid high and m_axis_data_tready low, tdata/tlast/tvalid hold stable.
REQ-026 m_axis_data_tvalid low in FILL; no output sample emitted twice or skipped.
REQ-027 frame_done pulses on the cycle after output handshake N*N-1; first input of next frame acceptable that same cycle.
REQ-028 Counters are log2(N*N) bits, wrap to 0 at frame end; no arithmetic overflow elsewhere.
REQ-029 Data passes bit-exact; no scaling, rounding or sign change.

Reset
REQ-030 Asserting reset at any time, including mid-FILL or mid-DRAIN, aborts the frame; memory contents are don't-care.
REQ-031 Reset values: state FILL, counters 0, s_axis_data_tready 0, m_axis_data_tvalid 0, m_axis_data_tlast 0, m_axis_data_tdata 0, all event pulses and frame_done 0.
REQ-032 s_axis_data_tready rises on the first posedge after reset deasserts.

Structure
REQ-033 Shared package fft2d_pkg holds N, W, LOG2N, sample width 2W, and the FILL/DRAIN state encoding.
REQ-034 Storage is one sub-module transpose_ram: simple dual-port N*N x 2W, one write port, one synchronous-read port (1-cycle latency), no reset, block-RAM inferable.
REQ-035 Output path contains a skid/holding register so REQ-024 and REQ-025 both hold with 1-cycle RAM latency.

Verification
REQ-036 Ramp: input k real = k, imag = 0, correct tlast, m_tready=1 -> outputs 0, 128, 256, ..., 16256, 1, 129, ..., last 16383; tlast on outputs 127, 255, ..., 16383; frame_done once.
REQ-037 Random m_tready (50%) and random s_tvalid gaps on ramp -> identical output sequence to REQ-036, no duplicates, data stable while stalled.
REQ-038 tlast asserted on input 5 and omitted on input 127 -> single event_tlast_unexpected pulse at handshake 5, single event_tlast_missing pulse at handshake 127; output still per REQ-036.
REQ-039 Reset asserted at output handshake 5000 -> all outputs per REQ-031 immediately; new ramp frame afterwards yields full REQ-036 sequence from 0.
REQ-040 Two back-to-back frames (second imag = k, real = 0) -> second frame output k imag = (k mod 128)*128 + k div 128; no input accepted during DRAIN.
